// File: rtl/id_pkg.sv
// Shared decode-stage definitions: opcodes, ALUOp/load-mode encodings, control bundle.
// The bypass variant is selected with the ID_WB_BYPASS_EN macro (see id_regfile).
package id_pkg;

    localparam int NREGS = 32;
    localparam int XLEN  = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_SLT   = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        LM_WORD   = 2'b00,
        LM_SEXT16 = 2'b01,
        LM_SEXT8  = 2'b10,
        LM_ZEXT8  = 2'b11
    } load_mode_e;

    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       branch;
        load_mode_e load_mode;
        alu_op_e    alu_op;
    } ctrl_t;

    function automatic ctrl_t mk_ctrl(logic rd, logic rw, logic as, logic mw, logic mr,
                                      logic mtr, logic br, load_mode_e lm, alu_op_e op);
        ctrl_t c;
        c.reg_dst    = rd;
        c.reg_write  = rw;
        c.alu_src    = as;
        c.mem_write  = mw;
        c.mem_read   = mr;
        c.mem_to_reg = mtr;
        c.branch     = br;
        c.load_mode  = lm;
        c.alu_op     = op;
        return c;
    endfunction

    function automatic logic [XLEN-1:0] extend_load(load_mode_e mode, logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (mode)
            LM_WORD:   r = d;
            LM_SEXT16: r = {{16{d[15]}}, d[15:0]};
            LM_SEXT8:  r = {{24{d[7]}}, d[7:0]};
            default:   r = {24'b0, d[7:0]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// 32x32 register file with load-width extension on the write-back port.
// Default: falling-edge write. ID_WB_BYPASS_EN: rising-edge write plus read bypass.
module id_regfile
    import id_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs_addr,
    input  logic [4:0]      rt_addr,
    output logic [XLEN-1:0] rs_data,
    output logic [XLEN-1:0] rt_data,
    input  logic [5:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            wr_en,
    input  logic [1:0]      wr_load_mode,
    input  logic [XLEN-1:0] reset_value
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [XLEN-1:0] wr_val;
    logic            wr_valid;

    assign wr_val   = extend_load(load_mode_e'(wr_load_mode), wr_data);
    assign wr_valid = wr_en && !wr_addr[5] && (wr_addr[4:0] != 5'd0);

    // Entry 0 is kept as a constant-zero flop so reads need no index-0 special case.
    always_comb begin
        regs_d    = regs_q;
        regs_d[0] = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (wr_valid && (wr_addr[4:0] == i[4:0])) begin
                regs_d[i] = wr_val;
            end
        end
    end

`ifdef ID_WB_BYPASS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q[0] <= '0;
            for (int i = 1; i < NREGS; i++) regs_q[i] <= reset_value;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
        if (wr_valid && (wr_addr[4:0] == rs_addr)) rs_data = wr_val;
        if (wr_valid && (wr_addr[4:0] == rt_addr)) rt_data = wr_val;
    end
`else
    // Mid-cycle write makes the new value visible to the following posedge capture.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q[0] <= '0;
            for (int i = 1; i < NREGS; i++) regs_q[i] <= reset_value;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
    end
`endif

endmodule

// File: rtl/id_decode_core.sv
// MIPS-subset decode stage: register file, main control decoder and ID/EX register.
// Optional ID_WB_BYPASS_EN selects the rising-edge write + bypass register file.
module id_decode_core
    import id_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic [31:0] in_new_pc_value,
    input  logic [5:0]  write_register,
    input  logic [31:0] write_data,
    input  logic        in_RegWrite,
    input  logic [1:0]  in_load_mode,
    input  logic [31:0] register_input,
    output logic [4:0]  instr_bits_15_11,
    output logic [4:0]  instr_bits_20_16,
    output logic [31:0] extended_bits,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    output logic [31:0] new_pc_value,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemToReg,
    output logic        Branch,
    output logic [1:0]  load_mode,
    output logic [2:0]  ALUOp
);

    logic [31:0] rs_data, rt_data;
    ctrl_t       ctrl_d, ctrl_q;
    logic [31:0] ext_d, ext_q, rd1_d, rd1_q, rd2_d, rd2_q, pc_d, pc_q;
    logic [4:0]  rd_d, rd_q, rt_d, rt_q;

    id_regfile u_regfile (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs_addr      (instruction[25:21]),
        .rt_addr      (instruction[20:16]),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .wr_addr      (write_register),
        .wr_data      (write_data),
        .wr_en        (in_RegWrite),
        .wr_load_mode (in_load_mode),
        .reset_value  (register_input)
    );

    // Unknown opcodes decode to an all-zero bubble.
    always_comb begin
        ctrl_d = '0;
        case (instruction[31:26])
            OP_RTYPE: ctrl_d = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LM_WORD,   ALU_FUNCT);
            OP_LW:    ctrl_d = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, LM_WORD,   ALU_ADD);
            OP_LH:    ctrl_d = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, LM_SEXT16, ALU_ADD);
            OP_LB:    ctrl_d = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, LM_SEXT8,  ALU_ADD);
            OP_LBU:   ctrl_d = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, LM_ZEXT8,  ALU_ADD);
            OP_SW:    ctrl_d = mk_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LM_WORD,   ALU_ADD);
            OP_BEQ:   ctrl_d = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, LM_WORD,   ALU_SUB);
            OP_ADDI:  ctrl_d = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LM_WORD,   ALU_ADD);
            OP_ANDI:  ctrl_d = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LM_WORD,   ALU_AND);
            OP_ORI:   ctrl_d = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LM_WORD,   ALU_OR);
            OP_SLTI:  ctrl_d = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LM_WORD,   ALU_SLT);
            default:  ctrl_d = '0;
        endcase
    end

    always_comb begin
        ext_d = {{16{instruction[15]}}, instruction[15:0]};
        rd1_d = rs_data;
        rd2_d = rt_data;
        pc_d  = in_new_pc_value;
        rd_d  = instruction[15:11];
        rt_d  = instruction[20:16];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            ext_q  <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            pc_q   <= '0;
            rd_q   <= '0;
            rt_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            ext_q  <= ext_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            pc_q   <= pc_d;
            rd_q   <= rd_d;
            rt_q   <= rt_d;
        end
    end

    assign instr_bits_15_11 = rd_q;
    assign instr_bits_20_16 = rt_q;
    assign extended_bits    = ext_q;
    assign read_data1       = rd1_q;
    assign read_data2       = rd2_q;
    assign new_pc_value     = pc_q;
    assign RegDst           = ctrl_q.reg_dst;
    assign RegWrite         = ctrl_q.reg_write;
    assign ALUSrc           = ctrl_q.alu_src;
    assign MemWrite         = ctrl_q.mem_write;
    assign MemRead          = ctrl_q.mem_read;
    assign MemToReg         = ctrl_q.mem_to_reg;
    assign Branch           = ctrl_q.branch;
    assign load_mode        = ctrl_q.load_mode;
    assign ALUOp            = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_decode_core.sv
// Scoreboard bench for id_decode_core: driver pushes expected ID/EX contents,
// monitor pops one entry per capture edge and compares.
module tb_id_decode_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction, in_new_pc_value, write_data, register_input;
    logic [5:0]  write_register;
    logic        in_RegWrite;
    logic [1:0]  in_load_mode;
    logic [4:0]  instr_bits_15_11, instr_bits_20_16;
    logic [31:0] extended_bits, read_data1, read_data2, new_pc_value;
    logic        RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch;
    logic [1:0]  load_mode;
    logic [2:0]  ALUOp;

    typedef struct {
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [31:0] ext;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [11:0] ctrl;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] pc_cnt  = 32'h0040_0000;

    // Control bundle: RegDst RegWrite ALUSrc MemWrite MemRead MemToReg Branch load_mode ALUOp
    localparam logic [11:0] C_R    = 12'b1100000_00_010;
    localparam logic [11:0] C_LW   = 12'b0110110_00_000;
    localparam logic [11:0] C_LH   = 12'b0110110_01_000;
    localparam logic [11:0] C_LB   = 12'b0110110_10_000;
    localparam logic [11:0] C_LBU  = 12'b0110110_11_000;
    localparam logic [11:0] C_SW   = 12'b0011000_00_000;
    localparam logic [11:0] C_BEQ  = 12'b0000001_00_001;
    localparam logic [11:0] C_ADDI = 12'b0110000_00_000;
    localparam logic [11:0] C_ANDI = 12'b0110000_00_011;
    localparam logic [11:0] C_ORI  = 12'b0110000_00_100;
    localparam logic [11:0] C_SLTI = 12'b0110000_00_101;
    localparam logic [11:0] C_NOP  = 12'b0000000_00_000;

    id_decode_core dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instruction      (instruction),
        .in_new_pc_value  (in_new_pc_value),
        .write_register   (write_register),
        .write_data       (write_data),
        .in_RegWrite      (in_RegWrite),
        .in_load_mode     (in_load_mode),
        .register_input   (register_input),
        .instr_bits_15_11 (instr_bits_15_11),
        .instr_bits_20_16 (instr_bits_20_16),
        .extended_bits    (extended_bits),
        .read_data1       (read_data1),
        .read_data2       (read_data2),
        .new_pc_value     (new_pc_value),
        .RegDst           (RegDst),
        .RegWrite         (RegWrite),
        .ALUSrc           (ALUSrc),
        .MemWrite         (MemWrite),
        .MemRead          (MemRead),
        .MemToReg         (MemToReg),
        .Branch           (Branch),
        .load_mode        (load_mode),
        .ALUOp            (ALUOp)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ctrl_now();
        return {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch, load_mode, ALUOp};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one decode cycle (plus optional WB) just after a posedge and queue the result.
    task automatic issue(input logic [31:0] instr, input logic [5:0] wreg, input logic [31:0] wdata,
                         input logic wen, input logic [1:0] lmode,
                         input logic [31:0] e_rd1, input logic [31:0] e_rd2, input logic [11:0] e_ctrl);
        exp_t e;
        @(posedge clk);
        #2;
        instruction     = instr;
        in_new_pc_value = pc_cnt;
        write_register  = wreg;
        write_data      = wdata;
        in_RegWrite     = wen;
        in_load_mode    = lmode;
        e.rd   = instr[15:11];
        e.rt   = instr[20:16];
        e.ext  = {{16{instr[15]}}, instr[15:0]};
        e.rd1  = e_rd1;
        e.rd2  = e_rd2;
        e.pc   = pc_cnt;
        e.ctrl = e_ctrl;
        sb_q.push_back(e);
        pc_cnt = pc_cnt + 32'd4;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ctrl",      {20'b0, ctrl_now()},       {20'b0, e.ctrl});
                chk("ext_bits",  extended_bits,             e.ext);
                chk("read1",     read_data1,                e.rd1);
                chk("read2",     read_data2,                e.rd2);
                chk("pc",        new_pc_value,              e.pc);
                chk("rd_field",  {27'b0, instr_bits_15_11}, {27'b0, e.rd});
                chk("rt_field",  {27'b0, instr_bits_20_16}, {27'b0, e.rt});
            end
        end
    end

    initial begin : driver
        int guard;
        rst_n           = 1'b0;
        register_input  = 32'hA5A5_0000;
        instruction     = 32'h8C85_00FC;
        in_new_pc_value = 32'h1234_5678;
        write_register  = 6'h03;
        write_data      = 32'hFFFF_FFFF;
        in_RegWrite     = 1'b0;
        in_load_mode    = 2'b00;
        #12;
        chk("rst_ctrl",  {20'b0, ctrl_now()},       32'h0);
        chk("rst_ext",   extended_bits,             32'h0);
        chk("rst_read1", read_data1,                32'h0);
        chk("rst_read2", read_data2,                32'h0);
        chk("rst_pc",    new_pc_value,              32'h0);
        chk("rst_rd",    {27'b0, instr_bits_15_11}, 32'h0);
        chk("rst_rt",    {27'b0, instr_bits_20_16}, 32'h0);
        #5 rst_n = 1'b1;

        issue(32'h0060_2020, 6'h00, 32'h0,          1'b0, 2'b00, 32'hA5A5_0000, 32'h0,          C_R);
        issue(32'hFFFF_FFFF, 6'h05, 32'h0000_80F0,  1'b1, 2'b01, 32'hA5A5_0000, 32'hA5A5_0000,  C_NOP);
        issue(32'h00A5_3020, 6'h00, 32'h0,          1'b0, 2'b00, 32'hFFFF_80F0, 32'hFFFF_80F0,  C_R);
        issue(32'h1000_FFFE, 6'h05, 32'h0000_80F0,  1'b1, 2'b11, 32'h0,         32'h0,          C_BEQ);
        issue(32'h00A5_3020, 6'h00, 32'h0,          1'b0, 2'b00, 32'h0000_00F0, 32'h0000_00F0,  C_R);
        issue(32'h00E0_0820, 6'h07, 32'h0000_1234,  1'b1, 2'b00, 32'h0000_1234, 32'h0,          C_R);
        issue(32'h8C85_00FC, 6'h00, 32'hDEAD_BEEF,  1'b1, 2'b00, 32'hA5A5_0000, 32'h0000_00F0,  C_LW);
        issue(32'hAC05_0010, 6'h25, 32'h1111_1111,  1'b1, 2'b00, 32'h0,         32'h0000_00F0,  C_SW);
        issue(32'h0005_1020, 6'h00, 32'h0,          1'b0, 2'b00, 32'h0,         32'h0000_00F0,  C_R);
        issue(32'h8400_0000, 6'h08, 32'h0000_0080,  1'b1, 2'b10, 32'h0,         32'h0,          C_LH);
        issue(32'h8100_8000, 6'h00, 32'h0,          1'b0, 2'b00, 32'hFFFF_FF80, 32'h0,          C_LB);
        issue(32'h9000_0001, 6'h00, 32'h0,          1'b0, 2'b00, 32'h0,         32'h0,          C_LBU);
        issue(32'h2000_0005, 6'h00, 32'h0,          1'b0, 2'b00, 32'h0,         32'h0,          C_ADDI);
        issue(32'h3000_7FFF, 6'h00, 32'h0,          1'b0, 2'b00, 32'h0,         32'h0,          C_ANDI);
        issue(32'h3400_0000, 6'h00, 32'h0,          1'b0, 2'b00, 32'h0,         32'h0,          C_ORI);
        issue(32'h2800_0000, 6'h00, 32'h0,          1'b0, 2'b00, 32'h0,         32'h0,          C_SLTI);

        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        chk("scoreboard_drain", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
